// File: rtl/flit_mon_pkg.sv
// Shared types, widths and helpers for the flit sink monitor.
// Holds the FSM state enum, counter widths and the saturating adder.
package flit_mon_pkg;

  localparam int CNT_W = 32;
  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Add b to a, clamping at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] a
  );
    return sat_add(a, CNT_W'(1));
  endfunction

endpackage

// File: rtl/flit_sink_monitor_popcount.sv
// Combinational population count of an N-bit word.
// Ports: data_i (N bits in), count_o (clog2(N+1) bits out).
module flit_popcount #(
  parameter int N = 21
) (
  input  logic [N-1:0]             data_i,
  output logic [$clog2(N+1)-1:0]   count_o
);

  localparam int CW = $clog2(N+1);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + CW'(data_i[i]);
    end
  end

endmodule

// File: rtl/flit_sink_monitor.sv
// Packet framing and statistics monitor for a flit stream sink.
// Ports: clk, rst_n (async low), clear, in_valid, in_data[N] in;
//   pkt_done, pkt_len[16], len_err, pkt_count, flit_count,
//   toggle_count (32 each), busy out.
// Define FLIT_MON_TOGGLE_EN to build bit-toggle counting.
module flit_sink_monitor
  import flit_mon_pkg::*;
#(
  parameter int N       = 21,
  parameter int PAYLOAD = 20,
  parameter int GAP_MIN = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             pkt_done,
  output logic [LEN_W-1:0] pkt_len,
  output logic             len_err,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] flit_count,
  output logic [CNT_W-1:0] toggle_count,
  output logic             busy
);

  localparam logic [7:0] GAP_LAST = 8'(GAP_MIN - 1);
  localparam logic [LEN_W-1:0] PAY_LEN = LEN_W'(PAYLOAD);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, len_inc;
  logic [7:0]       gap_q, gap_d;
  logic             close;

  assign len_inc = (len_q == {LEN_W{1'b1}}) ? len_q
                                            : len_q + 1'b1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    gap_d   = gap_q;
    close   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RECV;
          len_d   = LEN_W'(1);
        end
      end
      ST_RECV: begin
        if (in_valid) begin
          len_d = len_inc;
        end else if (GAP_MIN == 1) begin
          // A single idle cycle already closes the packet.
          state_d = ST_IDLE;
          close   = 1'b1;
        end else begin
          state_d = ST_GAP;
          gap_d   = 8'd1;
        end
      end
      ST_GAP: begin
        if (in_valid) begin
          state_d = ST_RECV;
          len_d   = len_inc;
          gap_d   = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          gap_d   = '0;
          close   = 1'b1;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
    end
  end

  logic             done_q;
  logic [LEN_W-1:0] plen_q, plen_d;
  logic             lerr_q, lerr_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  // clear overrides any same-cycle update; pkt_done is not a statistic.
  always_comb begin
    plen_d = plen_q;
    lerr_d = lerr_q;
    pcnt_d = pcnt_q;
    fcnt_d = fcnt_q;
    if (clear) begin
      plen_d = '0;
      lerr_d = 1'b0;
      pcnt_d = '0;
      fcnt_d = '0;
    end else begin
      if (close) begin
        plen_d = len_q;
        pcnt_d = sat_inc(pcnt_q);
        if (len_q != PAY_LEN) lerr_d = 1'b1;
      end
      if (in_valid) fcnt_d = sat_inc(fcnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      plen_q <= '0;
      lerr_q <= 1'b0;
      pcnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      done_q <= close;
      plen_q <= plen_d;
      lerr_q <= lerr_d;
      pcnt_q <= pcnt_d;
      fcnt_q <= fcnt_d;
    end
  end

`ifdef FLIT_MON_TOGGLE_EN
  localparam int PCW = $clog2(N+1);

  logic [N-1:0]     prev_q, prev_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic [PCW-1:0]   flips;

  flit_popcount #(.N(N)) u_pop (
    .data_i  (in_data ^ prev_q),
    .count_o (flips)
  );

  always_comb begin
    prev_d = prev_q;
    tog_d  = tog_q;
    if (clear) begin
      prev_d = '0;
      tog_d  = '0;
    end else if (in_valid) begin
      prev_d = in_data;
      tog_d  = sat_add(tog_q, CNT_W'(flips));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      tog_q  <= '0;
    end else begin
      prev_q <= prev_d;
      tog_q  <= tog_d;
    end
  end

  assign toggle_count = tog_q;
`else
  // Flit data only feeds toggle counting.
  logic unused_data;
  assign unused_data  = ^in_data;
  assign toggle_count = '0;
`endif

  assign pkt_done   = done_q;
  assign pkt_len    = plen_q;
  assign len_err    = lerr_q;
  assign pkt_count  = pcnt_q;
  assign flit_count = fcnt_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_flit_sink_monitor.sv
// Scoreboard bench for flit_sink_monitor.
// Packet-level reference model; monitor checks each pkt_done pulse.
module tb_flit_sink_monitor;

  localparam int N       = 21;
  localparam int PAYLOAD = 20;
  localparam int GAP_MIN = 7;
  localparam longint unsigned CMAX = 64'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic          pkt_done;
  logic [15:0]   pkt_len;
  logic          len_err;
  logic [31:0]   pkt_count;
  logic [31:0]   flit_count;
  logic [31:0]   toggle_count;
  logic          busy;

  flit_sink_monitor #(
    .N(N), .PAYLOAD(PAYLOAD), .GAP_MIN(GAP_MIN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .pkt_done     (pkt_done),
    .pkt_len      (pkt_len),
    .len_err      (len_err),
    .pkt_count    (pkt_count),
    .flit_count   (flit_count),
    .toggle_count (toggle_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned     edge_n;
    longint unsigned len;
    longint unsigned pcnt;
    longint unsigned fcnt;
    longint unsigned tog;
    bit              lerr;
  } ev_t;

  ev_t sbq[$];
  int  errors = 0;
  int  checks = 0;

  // Reference model state: statistics as the spec defines them.
  longint unsigned m_pcnt, m_fcnt, m_tog, m_len;
  bit              m_lerr;
  logic [N-1:0]    m_prev;
  int unsigned     cur_len, idle_run;
  bit              in_pkt;

  function automatic longint unsigned cap(
    input longint unsigned v, input longint unsigned mx
  );
    return (v > mx) ? mx : v;
  endfunction

  function void chk(
    input string name,
    input longint unsigned act,
    input longint unsigned exp
  );
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_pcnt = 0; m_fcnt = 0; m_tog = 0; m_len = 0;
    m_lerr = 0; m_prev = '0;
    cur_len = 0; idle_run = 0; in_pkt = 0;
  endtask

  // Issue one cycle of stimulus and advance the model to match.
  task automatic step(input bit v, input logic [N-1:0] d, input bit c);
    bit   closing;
    ev_t  e;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clear    = c;
    closing  = 0;
    if (v) begin
      cur_len  = int'(cap(cur_len + 1, 64'hFFFF));
      idle_run = 0;
      in_pkt   = 1;
    end else if (in_pkt) begin
      idle_run++;
      if (idle_run == GAP_MIN) closing = 1;
    end
    if (c) begin
      m_pcnt = 0; m_fcnt = 0; m_tog = 0;
      m_len = 0; m_lerr = 0; m_prev = '0;
    end else begin
      if (v) begin
        m_fcnt = cap(m_fcnt + 1, CMAX);
`ifdef FLIT_MON_TOGGLE_EN
        m_tog  = cap(m_tog + $countones(d ^ m_prev), CMAX);
        m_prev = d;
`endif
      end
      if (closing) begin
        m_pcnt = cap(m_pcnt + 1, CMAX);
        m_len  = cur_len;
        if (cur_len != PAYLOAD) m_lerr = 1;
      end
    end
    if (closing) begin
      e.edge_n = cyc + 1;
      e.len  = m_len;  e.pcnt = m_pcnt;
      e.fcnt = m_fcnt; e.tog  = m_tog;
      e.lerr = m_lerr;
      sbq.push_back(e);
      in_pkt = 0; cur_len = 0; idle_run = 0;
    end
  endtask

  task automatic flits(input int n);
    for (int i = 0; i < n; i++) step(1, N'($urandom), 0);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0);
  endtask

  task automatic check_all(input string tag);
    @(posedge clk);
    #1;
    chk({tag, ".pkt_count"}, pkt_count, m_pcnt);
    chk({tag, ".flit_count"}, flit_count, m_fcnt);
    chk({tag, ".toggle_count"}, toggle_count, m_tog);
    chk({tag, ".pkt_len"}, pkt_len, m_len);
    chk({tag, ".len_err"}, len_err, m_lerr);
    chk({tag, ".busy"}, busy, in_pkt);
  endtask

  // Monitor: every pkt_done pulse must match the oldest expected close.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) continue;
      if (pkt_done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pkt_done: got 1 expected 0 at %0d",
                   cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", cyc, e.edge_n);
          chk("done.pkt_len", pkt_len, e.len);
          chk("done.pkt_count", pkt_count, e.pcnt);
          chk("done.flit_count", flit_count, e.fcnt);
          chk("done.toggle_count", toggle_count, e.tog);
          chk("done.len_err", len_err, e.lerr);
        end
      end else if (sbq.size() > 0 && sbq[0].edge_n < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_pkt_done: got 0 expected 1 at %0d",
                 sbq[0].edge_n);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    int unsigned tog_exp;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.pkt_done", pkt_done, 0);
    chk("rst.busy", busy, 0);
    rst_n = 1'b1;
    check_all("reset");

    // Ten well-formed packets.
    for (int p = 0; p < 10; p++) begin
      flits(PAYLOAD);
      idles(GAP_MIN);
    end
    check_all("ten_pkts");
    chk("ten.pkt_count", pkt_count, 10);
    chk("ten.flit_count", flit_count, 200);
    chk("ten.len_err", len_err, 0);

    // Toggle counting across all-zero / all-one words.
    step(0, '0, 1);
    step(1, 21'h000000, 0);
    step(1, 21'h1FFFFF, 0);
    step(1, 21'h000000, 0);
    idles(GAP_MIN);
    check_all("toggles");
`ifdef FLIT_MON_TOGGLE_EN
    tog_exp = 42;
`else
    tog_exp = 0;
`endif
    chk("toggle_42", toggle_count, tog_exp);

    // Short packet sets a sticky length error.
    step(0, '0, 1);
    flits(19);
    idles(GAP_MIN);
    check_all("short");
    chk("short.pkt_len", pkt_len, 19);
    chk("short.len_err", len_err, 1);
    flits(PAYLOAD);
    idles(GAP_MIN);
    check_all("sticky");
    chk("sticky.len_err", len_err, 1);

    // Short gap merges bursts into one packet.
    step(0, '0, 1);
    flits(20);
    idles(3);
    flits(5);
    idles(GAP_MIN);
    check_all("merge");
    chk("merge.pkt_len", pkt_len, 25);
    chk("merge.pkt_count", pkt_count, 1);

    // Asynchronous reset mid-packet.
    flits(10);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    model_reset();
    chk("arst.flit_count", flit_count, 0);
    chk("arst.pkt_count", pkt_count, 0);
    chk("arst.pkt_len", pkt_len, 0);
    chk("arst.busy", busy, 0);
    chk("arst.pkt_done", pkt_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    flits(PAYLOAD);
    idles(GAP_MIN);
    check_all("post_rst");
    chk("post_rst.pkt_count", pkt_count, 1);

    // clear coinciding with a valid flit at flit_count=50.
    flits(30);
    idles(GAP_MIN);
    check_all("pre_clear");
    chk("pre_clear.flit_count", flit_count, 50);
    step(1, N'($urandom), 1);
    check_all("clear_flit");
    chk("clear_flit.flit_count", flit_count, 0);
    flits(PAYLOAD - 1);
    idles(GAP_MIN);
    check_all("after_clear");

    // Packet closing in the same cycle as clear.
    flits(PAYLOAD);
    idles(GAP_MIN - 1);
    step(0, '0, 1);
    check_all("close_clear");
    chk("close_clear.pkt_count", pkt_count, 0);

    // Randomized bursts, gaps and clears.
    for (int p = 0; p < 25; p++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        int nf;
        nf = $urandom_range(1, 25);
        for (int f = 0; f < nf; f++)
          step(1, N'($urandom), $urandom_range(0, 15) == 0);
        if (b != nb - 1) begin
          int ng;
          ng = $urandom_range(1, GAP_MIN - 1);
          for (int g = 0; g < ng; g++)
            step(0, '0, $urandom_range(0, 15) == 0);
        end
      end
      for (int g = 0; g < GAP_MIN + int'($urandom_range(0, 3)); g++)
        step(0, '0, $urandom_range(0, 15) == 0);
      check_all("rand");
    end

    idles(GAP_MIN + 2);
    check_all("final");
    chk("scoreboard_drain", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flit_sink_monitor.md
FLIT_SINK_MONITOR -- requirements
Module: flit_sink_monitor

Interface
REQ-001 SHALL have parameter N, default 21: flit data width in bits.
REQ-002 SHALL have parameter PAYLOAD, default 20: expected flits per packet.
REQ-003 SHALL have parameter GAP_MIN, default 7: idle cycles that close a packet (range 1..255).
REQ-004 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port clear  input  1: synchronous clear of statistics counters.
REQ-007 SHALL have port in_valid  input  1: flit present this cycle.
REQ-008 SHALL have port in_data  input  N: flit payload (adder sum output).
REQ-009 SHALL have port pkt_done  output  1: one-cycle pulse when a packet closes.
REQ-010 SHALL have port pkt_len  output  16: length of the last closed packet.
REQ-011 SHALL have port len_err  output  1: sticky; set when a closed packet's length is not PAYLOAD.
REQ-012 SHALL have port pkt_count  output  32: packets closed.
REQ-013 SHALL have port flit_count  output  32: valid flits received.
REQ-014 SHALL have port toggle_count  output  32: accumulated bit toggles between consecutive valid flits.
REQ-015 SHALL have port busy  output  1: high in RECV or GAP.

Function
REQ-016 SHALL implement FSM states IDLE, RECV, GAP.
REQ-017 IDLE: in_valid=1 -> RECV, length counter=1; else stay.
REQ-018 RECV: in_valid=1 -> increment length; in_valid=0 -> GAP, gap counter=1.
REQ-019 GAP: in_valid=1 -> RECV, increment length, gap counter cleared (short gap merges flits into same packet).
REQ-020 GAP: in_valid=0 and gap counter=GAP_MIN-1 -> IDLE, with pkt_done=1, pkt_len=length, pkt_count+1, len_err set if length!=PAYLOAD, all in the following cycle.
REQ-021 pkt_done SHALL be registered, latency exactly GAP_MIN cycles after the last valid flit's cycle.
REQ-022 Every valid flit SHALL increment flit_count and add popcount(in_data XOR prev_data) to toggle_count, then load prev_data=in_data.
REQ-023 prev_data SHALL persist across packets (gap does not reset it).
REQ-024 pkt_len SHALL hold its value until the next packet closes; length counter saturates at 16'hFFFF.
REQ-025 All 32-bit counters SHALL saturate at 32'hFFFFFFFF, no wrap.
REQ-026 clear=1 SHALL zero pkt_count, flit_count, toggle_count, len_err, pkt_len, prev_data next cycle; FSM and in-flight length unaffected.
REQ-027 clear and a counter update in the same cycle: clear wins, update discarded.
REQ-028 Packet closing with clear asserted: pkt_done still pulses, pkt_count reads 0 afterwards.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE and all outputs, counters, prev_data to 0.
REQ-030 Reset mid-packet SHALL abandon the packet with no pkt_done pulse.

Configuration
REQ-031 Macro FLIT_MON_TOGGLE_EN defined: toggle counting per REQ-022 compiled in.
REQ-032 Macro undefined: toggle logic and prev_data absent, toggle_count tied to 0; all else unchanged.

Structure
REQ-033 Package flit_mon_pkg SHALL hold the FSM state enum, CNT_W=32, LEN_W=16 and the saturating-increment helper.
REQ-034 Sub-module flit_popcount (N-bit input, clog2(N+1)-bit count, combinational) SHALL compute toggles.

Verification
REQ-035 10 packets of 20 valid flits, 7 idle cycles each -> pkt_count=10, flit_count=200, len_err=0, 10 pkt_done pulses each 7 cycles after the last flit.
REQ-036 Flits 0x000000, 0x1FFFFF, 0x000000 (N=21) -> toggle_count=42; with macro undefined -> 0.
REQ-037 Packet of 19 flits then 7 idle -> pkt_len=19, len_err=1, stays 1 through next good packet.
REQ-038 20 flits, 3 idle, 5 flits, 7 idle -> single pkt_done, pkt_len=25.
REQ-039 rst_n low after flit 10 of a packet -> all outputs 0 asynchronously, no pkt_done; next 20-flit packet -> pkt_count=1.
REQ-040 clear asserted with a valid flit while flit_count=50 -> flit_count=0 next cycle, that flit not counted.
